rgb_to_hsv_stream: RTL and testbench
====================================

# rgb_to_hsv_stream

Streaming RGB555-to-HSV converter that produces the hue/saturation/value pixel stream consumed by the ball colour classifier. It accepts one camera pixel at a time over a valid/ready handshake and computes HSV with a single shared iterative divider. It emits each result with a one-cycle `write` strobe and the pixel's horizontal position. It sits between the camera line capture and the colour classifier.

## Interface
- `BLACK_VAL`, default 4: value threshold for the dark fast path; only used with `HSV_BLACK_FASTPATH_EN`.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: converter can accept a pixel.
- `red`, `green`, `blue` in 5 each: input pixel components, 0..31.
- `horiz_count_in` in 10: column of the input pixel.
- `hue` out 9: 0..359 degrees.
- `saturation` out 5: 0..31.
- `value` out 5: 0..31.
- `horiz_count` out 10: column of the emitted pixel.
- `write` out 1: one-cycle strobe; the outputs are valid while it is high.

## Operation
- States: IDLE, MINMAX, DIV_S, DIV_H, HUE, OUT.
- IDLE: `in_ready`=1. On `in_valid` the block captures r, g, b and `horiz_count_in`, then goes to MINMAX.
- MINMAX:
  - Compute max, min and delta=max-min.
  - Select the dominant channel; ties resolve r > g > b.
  - Latch V=max.
- DIV_S:
  - Restoring divider, 11 iterations, one quotient bit per cycle.
  - Computes S = (delta*31)/max, truncated.
  - If max==0, S=0; the divider still runs the full 11 cycles.
- DIV_H:
  - Same divider computes q = (60*|d|)/delta, truncated.
  - d is g-b if r is dominant, b-r if g is dominant, r-g if b is dominant.
  - If delta==0, q=0.
  - Numerator is at most 1860 (11 bits); q is at most 60.
- HUE:
  - Base angle is 0, 120 or 240 for the r, g, b cases.
  - If d≥0: h = base+q. If d<0: h = base-q, plus 360 if negative.
  - Result 360 wraps to 0; result is always 0..359.
  - delta==0 gives hue 0.
- OUT: `write`=1 for exactly one cycle; `hue`/`saturation`/`value`/`horiz_count` hold until the next OUT. Next state IDLE.
- `in_ready`=0 in every state except IDLE; `in_valid` in those states is ignored and no pixel is lost.
- Reset:
  - Outputs: `hue`=0, `saturation`=0, `value`=0, `horiz_count`=0, `write`=0, `in_ready`=1 (state IDLE).
  - Reset asserted mid-conversion aborts it; no `write` is emitted for the aborted pixel.

## Timing
- Accept edge = cycle 0.
- MINMAX is cycle 1, DIV_S cycles 2-12, DIV_H cycles 13-23, HUE cycle 24.
- `write` is high in cycle 25.
- IDLE in cycle 26; `in_ready`=1 again there.
- Sustained throughput: one pixel per 26 cycles when `in_valid` is held high.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `HSV_BLACK_FASTPATH_EN` defined:
  - In MINMAX, if max < `BLACK_VAL`, the block goes directly to OUT.
  - Emitted result: hue=0, saturation=0, value=max.
  - `write` is high in cycle 2; IDLE in cycle 3.
- Undefined:
  - All pixels take the full 25-cycle path.
  - `BLACK_VAL` is unused.

## Test plan
- (31,0,0), col 100 -> `write` at cycle 25 with hue 0, sat 31, val 31, horiz_count 100.
- (0,31,0) -> hue 120, sat 31, val 31. (31,0,15) -> hue 331 (q=900/31=29), sat 31.
- (16,16,16) -> hue 0, sat 0, val 16. (20,10,10) -> hue 0, sat 15, val 20.
- `in_valid` held for two pixels -> second accepted at cycle 26, second `write` at cycle 51; `in_ready` low in cycles 1-25.
- (2,1,0), `BLACK_VAL`=4:
  - With macro -> `write` at cycle 2; hue 0, sat 0, val 2.
  - Without -> `write` at cycle 25; hue 30, sat 31, val 2.
- `rst_n` low at cycle 10 of a conversion -> no `write`; all outputs 0 and `in_ready`=1 on the following edge; a new pixel converts normally after reset releases.

Source files
------------

// File: rtl/rgb_to_hsv_stream.sv
// Streaming RGB555 -> HSV converter built around one shared 11-step restoring divider.
// Defining HSV_BLACK_FASTPATH_EN lets pixels with max < BLACK_VAL skip straight to output.
module rgb_to_hsv_stream #(
  parameter int unsigned BLACK_VAL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] red,
  input  logic [4:0] green,
  input  logic [4:0] blue,
  input  logic [9:0] horiz_count_in,
  output logic [8:0] hue,
  output logic [4:0] saturation,
  output logic [4:0] value,
  output logic [9:0] horiz_count,
  output logic       write
);
  typedef enum logic [2:0] {IDLE, MINMAX, DIV_S, DIV_H, HUE, OUT} state_t;
  typedef enum logic [1:0] {DOM_R, DOM_G, DOM_B} dom_t;
  localparam logic [3:0] LAST_ITER = 4'd10;

  state_t      state, state_next;
  logic [4:0]  r_q, g_q, b_q;
  logic [9:0]  col_q;
  logic [4:0]  max_q, delta_q, d_abs_q, sat_q;
  logic        d_neg_q;
  dom_t        dom_q;
  logic [5:0]  q_h;
  logic [10:0] div_num;
  logic [5:0]  div_rem;
  logic [4:0]  div_den;
  logic [3:0]  iter;

  // Channel ordering on the captured pixel; ties favour r, then g.
  logic [4:0] mx, mn, dl, d_abs;
  logic [5:0] d;
  dom_t       dom;
  logic       black_hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dom = DOM_R;
    mx  = r_q;
    d   = {1'b0, g_q} - {1'b0, b_q};
    if (r_q >= g_q && r_q >= b_q) begin
      dom = DOM_R;
      mx  = r_q;
      d   = {1'b0, g_q} - {1'b0, b_q};
    end else if (g_q >= b_q) begin
      dom = DOM_G;
      mx  = g_q;
      d   = {1'b0, b_q} - {1'b0, r_q};
    end else begin
      dom = DOM_B;
      mx  = b_q;
      d   = {1'b0, r_q} - {1'b0, g_q};
    end
    mn = r_q;
    if (g_q < mn) mn = g_q;
    if (b_q < mn) mn = b_q;
    dl    = mx - mn;
    d_abs = d[5] ? 5'(-d) : d[4:0];
  end

`ifdef HSV_BLACK_FASTPATH_EN
  assign black_hit = (32'(mx) < BLACK_VAL);
`else
  assign black_hit = 1'b0;
  // BLACK_VAL only matters when the dark fast path is built in.
  logic unused_black_val;
  assign unused_black_val = (BLACK_VAL == 0);
`endif

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  logic [6:0]  rem_sh;
  logic        div_ge;
  logic [5:0]  rem_next;
  logic [10:0] quo_next;

  always_comb begin
    rem_sh   = {div_rem, div_num[10]};
    div_ge   = (rem_sh >= {2'b00, div_den});
    rem_next = div_ge ? 6'(rem_sh - {2'b00, div_den}) : rem_sh[5:0];
    quo_next = {div_num[9:0], div_ge};
  end

  logic [8:0] base, hue_calc;

  always_comb begin
    case (dom_q)
      DOM_G:   base = 9'd120;
      DOM_B:   base = 9'd240;
      default: base = 9'd0;
    endcase
    if (d_neg_q)
      hue_calc = (base < 9'(q_h)) ? base + 9'd360 - 9'(q_h) : base - 9'(q_h);
    else
      hue_calc = base + 9'(q_h);
    if (hue_calc == 9'd360 || delta_q == 5'd0) hue_calc = 9'd0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MINMAX;
      MINMAX:  state_next = black_hit ? OUT : DIV_S;
      DIV_S:   if (iter == LAST_ITER) state_next = DIV_H;
      DIV_H:   if (iter == LAST_ITER) state_next = HUE;
      HUE:     state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hue         <= '0;
      saturation  <= '0;
      value       <= '0;
      horiz_count <= '0;
      write       <= 1'b0;
    end else begin
      write <= (state_next == OUT);
      if (state == HUE) begin
        hue         <= hue_calc;
        saturation  <= sat_q;
        value       <= max_q;
        horiz_count <= col_q;
      end else if (state == MINMAX && black_hit) begin
        hue         <= '0;
        saturation  <= '0;
        value       <= mx;
        horiz_count <= col_q;
      end
    end
  end

  // NOTE: datapath registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        r_q   <= red;
        g_q   <= green;
        b_q   <= blue;
        col_q <= horiz_count_in;
      end
      MINMAX: begin
        max_q   <= mx;
        delta_q <= dl;
        dom_q   <= dom;
        d_neg_q <= d[5];
        d_abs_q <= d_abs;
        div_num <= 11'(dl) * 11'd31;
        div_rem <= '0;
        div_den <= mx;
        iter    <= '0;
      end
      DIV_S: begin
        div_num <= quo_next;
        div_rem <= rem_next;
        iter    <= iter + 4'd1;
        if (iter == LAST_ITER) begin
          sat_q   <= (max_q == 5'd0) ? 5'd0 : quo_next[4:0];
          div_num <= 11'(d_abs_q) * 11'd60;
          div_rem <= '0;
          div_den <= delta_q;
          iter    <= '0;
        end
      end
      DIV_H: begin
        div_num <= quo_next;
        div_rem <= rem_next;
        iter    <= iter + 4'd1;
        if (iter == LAST_ITER) q_h <= (delta_q == 5'd0) ? 6'd0 : quo_next[5:0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rgb_to_hsv_stream.sv
// Self-checking bench for rgb_to_hsv_stream: integer HSV model plus scoreboard checked every cycle,
// and directed pixels with hand-computed results. Follows HSV_BLACK_FASTPATH_EN if defined.
module tb_rgb_to_hsv_stream;
  localparam int BLACK_VAL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] red = '0, green = '0, blue = '0;
  logic [9:0] horiz_count_in = '0;
  logic [8:0] hue;
  logic [4:0] saturation, value;
  logic [9:0] horiz_count;
  logic       write;

  rgb_to_hsv_stream #(.BLACK_VAL(BLACK_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .red(red), .green(green), .blue(blue), .horiz_count_in(horiz_count_in),
    .hue(hue), .saturation(saturation), .value(value),
    .horiz_count(horiz_count), .write(write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // HSV straight from the definitions, in plain integer arithmetic.
  function automatic void model(input int r, input int g, input int b,
                                output int h, output int s, output int v, output int lat);
    int mx, mn, dl, d, base, q;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    dl = mx - mn;
    v = mx;
    s = (mx == 0) ? 0 : (dl * 31) / mx;
    h = 0;
    lat = 25;
    if (dl != 0) begin
      if (r >= g && r >= b) begin d = g - b; base = 0;   end
      else if (g >= b)      begin d = b - r; base = 120; end
      else                  begin d = r - g; base = 240; end
      q = (60 * ((d < 0) ? -d : d)) / dl;
      h = (d >= 0) ? base + q : base - q;
      if (h < 0) h += 360;
      if (h == 360) h = 0;
    end
`ifdef HSV_BLACK_FASTPATH_EN
    if (mx < BLACK_VAL) begin h = 0; s = 0; lat = 2; end
`endif
  endfunction

  typedef struct {int h; int s; int v; int col; int due;} exp_t;
  exp_t sb[$];
  int   last_due = 0;
  int   exp_h = 0, exp_s = 0, exp_v = 0, exp_c = 0;
  bit   primed = 1'b0;

  // Scoreboard compare on the falling edge, then predict what the next rising edge does.
  always @(negedge clk) begin
    exp_t e;
    int h, s, v, lat;
    if (primed) begin
      check("in_ready", int'(in_ready), int'(cyc > last_due));
      if (write) begin
        if (sb.size() == 0) check("spurious_write", int'(write), 0);
        else begin
          e = sb.pop_front();
          check("write_cycle", cyc, e.due);
          exp_h = e.h; exp_s = e.s; exp_v = e.v; exp_c = e.col;
        end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        check("write_strobe", int'(write), 1);
        sb.delete(0);
      end
      check("hue", int'(hue), exp_h);
      check("saturation", int'(saturation), exp_s);
      check("value", int'(value), exp_v);
      check("horiz_count", int'(horiz_count), exp_c);
    end
    if (!rst_n) begin
      primed = 1'b1;
      sb.delete();
      last_due = cyc;
      exp_h = 0; exp_s = 0; exp_v = 0; exp_c = 0;
    end else if (in_valid && in_ready) begin
      model(int'(red), int'(green), int'(blue), h, s, v, lat);
      sb.push_back('{h: h, s: s, v: v, col: int'(horiz_count_in), due: cyc + lat});
      last_due = cyc + lat;
    end
  end

  task automatic send(input int r, input int g, input int b, input int col, output int a_cyc);
    bit got;
    got = 1'b0;
    a_cyc = -1;
    @(posedge clk); #2;
    in_valid = 1'b1;
    red = 5'(r); green = 5'(g); blue = 5'(b); horiz_count_in = 10'(col);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin a_cyc = cyc; got = 1'b1; break; end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_write(input int a_cyc, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (write) begin lat = cyc - a_cyc; break; end
    end
    if (lat < 0) check("write_timeout", lat, 0);
  endtask

  task automatic run_px(input string name, input int r, input int g, input int b, input int col,
                        input int e_lat, input int e_h, input int e_s, input int e_v);
    int a, lat;
    send(r, g, b, col, a);
    wait_write(a, lat);
    check({name, "_latency"}, lat, e_lat);
    check({name, "_hue"}, int'(hue), e_h);
    check({name, "_sat"}, int'(saturation), e_s);
    check({name, "_val"}, int'(value), e_v);
    check({name, "_col"}, int'(horiz_count), col);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
    $fatal(1, "bench timeout");
  end

  initial begin
    int h, s, v, lat, a1, a2, nw;
    int extra [8][3] = '{'{0,0,0}, '{31,31,0}, '{0,31,31}, '{31,0,31},
                         '{5,0,31}, '{0,0,1}, '{3,3,0}, '{31,30,29}};

    // Pin the model to hand-derived values.
    model(31, 0, 0, h, s, v, lat);
    check("model_red_h", h, 0);   check("model_red_s", s, 31);   check("model_red_v", v, 31);
    model(31, 0, 15, h, s, v, lat);
    check("model_mag_h", h, 331); check("model_mag_s", s, 31);
    model(20, 10, 10, h, s, v, lat);
    check("model_pink_h", h, 0);  check("model_pink_s", s, 15);  check("model_pink_v", v, 20);
    model(5, 0, 31, h, s, v, lat);
    check("model_blue_h", h, 249);
    model(31, 0, 31, h, s, v, lat);
    check("model_wrap_h", h, 300);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_write", int'(write), 0);
    check("reset_hue", int'(hue), 0);
    check("reset_value", int'(value), 0);

    run_px("red",   31, 0, 0, 100, 25, 0, 31, 31);
    run_px("green", 0, 31, 0, 5, 25, 120, 31, 31);
    run_px("mag",   31, 0, 15, 6, 25, 331, 31, 31);
    run_px("grey",  16, 16, 16, 7, 25, 0, 0, 16);
    run_px("pink",  20, 10, 10, 8, 25, 0, 15, 20);
`ifdef HSV_BLACK_FASTPATH_EN
    run_px("dark",  2, 1, 0, 9, 2, 0, 0, 2);
`else
    run_px("dark",  2, 1, 0, 9, 25, 30, 31, 2);
`endif

    // in_valid held across two pixels.
    @(posedge clk); #2;
    in_valid = 1'b1; red = 5'd31; green = 5'd0; blue = 5'd0; horiz_count_in = 10'd200;
    a1 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin a1 = cyc; break; end
    end
    @(posedge clk); #2;
    red = 5'd0; green = 5'd31; blue = 5'd0; horiz_count_in = 10'd201;
    wait_write(a1, lat);
    check("b2b_first_write", lat, 25);
    a2 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin a2 = cyc; break; end
    end
    check("b2b_second_accept", a2 - a1, 26);
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_write(a1, lat);
    check("b2b_second_write", lat, 51);
    check("b2b_second_hue", int'(hue), 120);
    check("b2b_second_col", int'(horiz_count), 201);

    // Reset in cycle 10 of a conversion aborts it.
    send(31, 0, 15, 300, a1);
    do begin @(posedge clk); #2; end while (cyc < a1 + 10);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_hue", int'(hue), 0);
    check("abort_sat", int'(saturation), 0);
    check("abort_val", int'(value), 0);
    check("abort_col", int'(horiz_count), 0);
    nw = 0;
    repeat (35) begin
      @(negedge clk);
      if (write) nw++;
    end
    check("abort_no_write", nw, 0);
    run_px("post_reset", 20, 10, 10, 301, 25, 0, 15, 20);

    // Boundary vectors checked through the scoreboard only.
    foreach (extra[i]) begin
      send(extra[i][0], extra[i][1], extra[i][2], 400 + i, a1);
      wait_write(a1, lat);
    end
    for (int i = 0; i < 6; i++) begin
      send(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)), 500 + i, a1);
      wait_write(a1, lat);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
